// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC scan sequencer: FSM state encoding and
// default sizing used by the top level.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CONV    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int DEF_SIZE     = 8;
  localparam int DEF_NCH      = 4;
  localparam int DEF_CHW      = 2;
  localparam int DEF_SETTLE_W = 8;
  localparam int DEF_FDEPTH   = 4;

endpackage

// File: rtl/adc_res_fifo.sv
// Result FIFO with a registered head output. A push and a pop in the same
// cycle are both honoured, even when the FIFO is full.
module adc_res_fifo #(
  parameter int WIDTH  = 10,
  parameter int FDEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FDEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [FDEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      wr_ptr_next, rd_ptr_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign wr_ptr_next = do_push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
  assign rd_ptr_next = do_pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

  // The head register tracks the entry that will be at the head next cycle;
  // a write landing in that slot is forwarded straight from din.
  always_comb begin
    head_next = mem[rd_ptr_next[AW-1:0]];
    if (do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
      head_next = din;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
    end
  end

  assign dout = head_reg;

endmodule

// File: rtl/adc_seq_ctrl.sv
// Multi-channel scan sequencer: selects a mux channel, settles, runs one SAR
// conversion per masked channel and queues channel-tagged results.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int NCH      = DEF_NCH,
  parameter int CHW      = DEF_CHW,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int FDEPTH   = DEF_FDEPTH
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                trig,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic [CHW-1:0]      ch_sel,
  output logic                sar_start,
  input  logic                sar_done,
  input  logic [SIZE-1:0]     sar_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [SIZE-1:0]     res_data,
  output logic [CHW-1:0]      res_ch,
  output logic                busy,
  output logic                overrun,
  input  logic                clr_ovr
);

  state_t              state_reg, state_next;
  logic [CHW-1:0]      ch_sel_reg, ch_sel_next;
  logic [NCH-1:0]      scan_mask_reg, scan_mask_next;
  logic [SETTLE_W-1:0] cnt_reg, cnt_next;
  logic                overrun_reg;

  logic [NCH-1:0]      above_mask;
  logic [CHW-1:0]      first_ch, next_ch;
  logic                scan_last;
  logic                push_req, pop, fifo_full, fifo_empty;
  logic [SIZE+CHW-1:0] fifo_dout;

  // Masked channels strictly above the current one.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_above
      assign above_mask[gi] = scan_mask_reg[gi] & (CHW'(gi) > ch_sel_reg);
    end
  endgenerate

  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i])    first_ch = CHW'(i);
      if (above_mask[i]) next_ch  = CHW'(i);
    end
  end

  assign scan_last = ~|above_mask;

  always_comb begin
    state_next     = state_reg;
    ch_sel_next    = ch_sel_reg;
    scan_mask_next = scan_mask_reg;
    cnt_next       = cnt_reg;
    push_req       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if ((en | trig) && |ch_mask) begin
          scan_mask_next = ch_mask;
          ch_sel_next    = first_ch;
          cnt_next       = settle_cyc;
          state_next     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_reg == '0) state_next = S_CONV;
        else               cnt_next   = cnt_reg - SETTLE_W'(1);
      end
      S_CONV: begin
        if (sar_done) begin
          push_req   = 1'b1;
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!sar_done) begin
          if (!scan_last) begin
            ch_sel_next = next_ch;
            cnt_next    = settle_cyc;
            state_next  = S_SETTLE;
          end else if (en && |ch_mask) begin
            // Continuous mode: back-to-back scan without an IDLE cycle.
            scan_mask_next = ch_mask;
            ch_sel_next    = first_ch;
            cnt_next       = settle_cyc;
            state_next     = S_SETTLE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      ch_sel_reg    <= '0;
      scan_mask_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      ch_sel_reg    <= ch_sel_next;
      scan_mask_reg <= scan_mask_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign pop = res_valid & res_ready;

  // A result is only lost when the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge clk) begin
    if (!rstn)                             overrun_reg <= 1'b0;
    else if (push_req && fifo_full && !pop) overrun_reg <= 1'b1;
    else if (clr_ovr)                      overrun_reg <= 1'b0;
  end

  adc_res_fifo #(
    .WIDTH (SIZE + CHW),
    .FDEPTH(FDEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push_req),
    .din  ({ch_sel_reg, sar_out}),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ch_sel    = ch_sel_reg;
  assign sar_start = (state_reg == S_CONV);
  assign busy      = (state_reg != S_IDLE);
  assign overrun   = overrun_reg;
  assign res_valid = ~fifo_empty;
  assign res_data  = fifo_dout[SIZE-1:0];
  assign res_ch    = fifo_dout[SIZE+CHW-1:SIZE];

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl with a behavioural SAR core that answers
// start with done after SIZE+2 cycles, returning a per-channel code.
module tb_adc_seq_ctrl;

  localparam int SIZE = 8, NCH = 4, CHW = 2, SETTLE_W = 8, FDEPTH = 4;

  logic                clk = 1'b0;
  logic                rstn, en, trig, res_ready, clr_ovr;
  logic [NCH-1:0]      ch_mask;
  logic [SETTLE_W-1:0] settle_cyc;
  logic [CHW-1:0]      ch_sel, res_ch;
  logic                sar_start, res_valid, busy, overrun;
  logic                sar_done = 1'b0;
  logic [SIZE-1:0]     sar_out = '0;
  logic [SIZE-1:0]     res_data;

  int errors = 0, checks = 0;
  int n_starts = 0;
  logic start_d = 1'b0;
  int sar_cnt = 0;
  logic [7:0] ain_code [4];
  int got_q [$];
  logic mon_en = 1'b0;
  int n;

  // Codes at 1.8 V full scale: ch0 0.12 V, ch1 0.24 V, ch2 0.60 V, ch3 1.20 V.
  localparam int CODE0 = 17, CODE1 = 34, CODE2 = 85, CODE3 = 170;

  always #5 clk = ~clk;

  adc_seq_ctrl #(.SIZE(SIZE), .NCH(NCH), .CHW(CHW), .SETTLE_W(SETTLE_W), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rstn(rstn), .en(en), .trig(trig), .ch_mask(ch_mask),
    .settle_cyc(settle_cyc), .ch_sel(ch_sel), .sar_start(sar_start),
    .sar_done(sar_done), .sar_out(sar_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
    .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always @(posedge clk) begin
    if (!sar_start) begin
      sar_done <= 1'b0;
      sar_cnt  <= 0;
    end else if (!sar_done) begin
      if (sar_cnt == SIZE + 1) begin
        sar_done <= 1'b1;
        sar_out  <= ain_code[ch_sel];
      end
      sar_cnt <= sar_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (sar_start === 1'b1 && start_d !== 1'b1) n_starts <= n_starts + 1;
    start_d <= sar_start;
    if (mon_en && res_valid === 1'b1 && res_ready === 1'b1)
      got_q.push_back(int'(res_ch) * 256 + int'(res_data));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %-14s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %-14s %0d", tag, got);
    end
  endtask

  task automatic pop_check(input string tag, input int ch, input int data);
    chk({tag, "_v"}, res_valid, 1);
    chk({tag, "_ch"}, res_ch, ch);
    chk({tag, "_d"}, res_data, data);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 400) begin @(negedge clk); k++; end
    chk(tag, k < 400, 1);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ain_code[0] = 8'(CODE0); ain_code[1] = 8'(CODE1);
    ain_code[2] = 8'(CODE2); ain_code[3] = 8'(CODE3);
    rstn = 1'b0; en = 1'b0; trig = 1'b0; ch_mask = '0; settle_cyc = '0;
    res_ready = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", sar_start, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_chsel", ch_sel, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_data", res_data, 0);
    chk("rst_ch", res_ch, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single scan over ch1/ch3, with a trigger pulse in the middle of it.
    ch_mask = 4'b1010; settle_cyc = 8'd3;
    pulse_trig();
    chk("ss_busy", busy, 1);
    chk("ss_chsel", ch_sel, 1);
    chk("ss_start0", sar_start, 0);
    n = 0;
    while (!sar_start && n < 50) begin @(negedge clk); n++; end
    chk("ss_settle_lat", n, 4);
    pulse_trig();
    wait_idle("ss_idle");
    chk("ss_starts", n_starts, 2);
    repeat (20) @(negedge clk);
    chk("ss_no_rescan", n_starts, 2);
    pop_check("ss_r0", 1, CODE1);
    pop_check("ss_r1", 3, CODE3);
    chk("ss_empty", res_valid, 0);

    // Empty mask: a trigger must not start anything.
    ch_mask = 4'b0000;
    pulse_trig();
    chk("em_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("em_busy2", busy, 0);
    chk("em_starts", n_starts, 2);

    // Continuous scan; en drops during the second pass over ch2.
    settle_cyc = 8'd0; ch_mask = 4'b1111; res_ready = 1'b1;
    got_q.delete();
    mon_en = 1'b1; en = 1'b1;
    n = 0;
    while (got_q.size() < 6 && n < 600) begin @(negedge clk); n++; end
    chk("cs_six_tmo", n < 600, 1);
    n = 0;
    while (!(sar_start && ch_sel == 2) && n < 100) begin @(negedge clk); n++; end
    chk("cs_ch2_tmo", n < 100, 1);
    en = 1'b0;
    wait_idle("cs_idle");
    repeat (3) @(negedge clk);
    mon_en = 1'b0; res_ready = 1'b0;
    chk("cs_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk($sformatf("cs_res%0d", i), got_q[i],
          (i % 4) * 256 + ((i % 4) == 0 ? CODE0 : (i % 4) == 1 ? CODE1 :
                           (i % 4) == 2 ? CODE2 : CODE3));
    repeat (20) @(negedge clk);
    chk("cs_stays_idle", busy, 0);

    // Overrun: consumer stalled, continuous scan overflows on the 5th result.
    ch_mask = 4'b1111; en = 1'b1;
    n = 0;
    while (!overrun && n < 600) begin @(negedge clk); n++; end
    chk("ov_tmo", n < 600, 1);
    en = 1'b0;
    chk("ov_set", overrun, 1);
    wait_idle("ov_idle");
    chk("ov_sticky", overrun, 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ov_clr", overrun, 0);
    pop_check("ov_r0", 0, CODE0);
    pop_check("ov_r1", 1, CODE1);
    pop_check("ov_r2", 2, CODE2);
    pop_check("ov_r3", 3, CODE3);
    chk("ov_empty", res_valid, 0);

    // Full FIFO: a pop in the capture cycle keeps the new entry, no overrun.
    ch_mask = 4'b1111;
    pulse_trig();
    wait_idle("fp_fill_idle");
    chk("fp_fill_ovr", overrun, 0);
    ain_code[0] = 8'h5A;
    ch_mask = 4'b0001;
    pulse_trig();
    n = 0;
    while (!(sar_start && sar_done) && n < 100) begin @(negedge clk); n++; end
    chk("fp_done_tmo", n < 100, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("fp_ovr", overrun, 0);
    wait_idle("fp_idle");
    pop_check("fp_r0", 1, CODE1);
    pop_check("fp_r1", 2, CODE2);
    pop_check("fp_r2", 3, CODE3);
    pop_check("fp_r3", 0, 'h5A);
    chk("fp_empty", res_valid, 0);
    ain_code[0] = 8'(CODE0);

    // Reset while converting ch2, with a ch0 result already queued.
    ch_mask = 4'b0101; en = 1'b1;
    n = 0;
    while (!(sar_start && ch_sel == 2) && n < 200) begin @(negedge clk); n++; end
    chk("rc_tmo", n < 200, 1);
    chk("rc_pre_valid", res_valid, 1);
    rstn = 1'b0; en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rc_start", sar_start, 0);
    chk("rc_busy", busy, 0);
    chk("rc_valid", res_valid, 0);
    chk("rc_chsel", ch_sel, 0);
    chk("rc_data", res_data, 0);
    repeat (5) @(negedge clk);
    chk("rc_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Multi-channel scan sequencer for the SAR ADC core. It selects an analog mux channel, waits a programmable settling time, then runs one SAR conversion through the core's `start`/`done` handshake. Each result is pushed, tagged with its channel, into a small result FIFO. It sits between the register/bus side and the `SAR` instance, and owns the SAR's `start` input and the external mux select.

## Interface
Parameters:
- `SIZE`, 8, SAR resolution; width of result data.
- `NCH`, 4, number of analog channels.
- `CHW`, 2, channel index width; `2**CHW >= NCH`.
- `SETTLE_W`, 8, width of the settle-time field.
- `FDEPTH`, 4, result FIFO depth; power of two.

Ports:
- `clk` in 1: single clock, shared with the SAR core.
- `rstn` in 1: reset; synchronous, active-low.
- `en` in 1: continuous scan enable.
- `trig` in 1: single-scan request, one-cycle pulse.
- `ch_mask` in NCH: channels included in a scan.
- `settle_cyc` in SETTLE_W: settle cycles minus one.
- `ch_sel` out CHW: analog mux select.
- `sar_start` out 1: to the SAR `start` input.
- `sar_done` in 1: from the SAR `done` output.
- `sar_out` in SIZE: from the SAR `out` output.
- `res_valid` out 1: FIFO non-empty.
- `res_ready` in 1: consumer pop.
- `res_data` out SIZE: result at the FIFO head.
- `res_ch` out CHW: channel tag of the head entry.
- `busy` out 1: scan in progress.
- `overrun` out 1: sticky, set when a result is dropped.
- `clr_ovr` in 1: clears `overrun`.

## Operation
State machine: IDLE, SETTLE, CONV, RELEASE.
- **IDLE**
  - A scan starts when `(en | trig) & |ch_mask`.
  - `ch_mask` is latched into `scan_mask` at scan start.
  - `ch_sel` is set to the lowest set bit of `scan_mask`.
  - The settle counter loads `settle_cyc`; go to SETTLE.
  - `ch_mask == 0`: stay in IDLE and never assert `sar_start`.
- **SETTLE**
  - The counter decrements each cycle.
  - At count 0, go to CONV.
  - Dwell is `settle_cyc + 1` cycles; `settle_cyc = 0` gives 1 cycle.
- **CONV**
  - `sar_start = 1`.
  - When `sar_done` is sampled high:
    - capture `{ch_sel, sar_out}`;
    - push it to the FIFO, or drop it and set `overrun` if the FIFO is full;
    - deassert `sar_start` on that same edge;
    - go to RELEASE.
- **RELEASE**
  - Wait for `sar_done` low.
  - If a higher set bit remains in `scan_mask`:
    - `ch_sel` moves to the next set bit (ascending);
    - the settle counter reloads;
    - go to SETTLE.
  - Otherwise the scan is complete:
    - if `en` is high, start a new scan immediately, re-latching `ch_mask` and behaving as in IDLE;
    - else go to IDLE.
- `trig` outside IDLE (including RELEASE at scan end): ignored.
- `en` dropped mid-scan: the current scan finishes on every masked channel; no restart.
- `ch_mask` changes mid-scan: no effect until the next scan start.
- `ch_sel` is stable from SETTLE entry through RELEASE exit.
- `busy = (state != IDLE)`.
- FIFO behaviour:
  - pop when `res_valid & res_ready`;
  - push and pop in the same cycle are both honoured, including when full (the entry is not dropped; no overrun);
  - pop when empty: ignored.
- `overrun`:
  - set has priority over `clr_ovr` in the same cycle;
  - `clr_ovr` otherwise clears it.

## Timing
- Reset (`rstn` low at a `clk` edge), at any point including mid-conversion:
  - state IDLE;
  - `sar_start = 0`, `ch_sel = 0`, `busy = 0`;
  - `res_valid = 0`, FIFO pointers cleared;
  - `overrun = 0`, `res_data = 0`, `res_ch = 0`.
- IDLE with a start condition at edge N: SETTLE from N+1.
- SETTLE → CONV: `sar_start` is high starting `settle_cyc + 1` cycles after SETTLE entry.
- `sar_done` high sampled at edge M:
  - FIFO write at M;
  - `res_valid` high after M;
  - `sar_start` low after M.
- `res_data`/`res_ch` are registered FIFO head outputs, valid whenever `res_valid` is high.
- Per-channel cost: `settle_cyc + 1` + SAR conversion (SIZE+2 cycles for the core) + 1 cycle CONV entry + ≥1 cycle RELEASE.

## Structure
- Shared package `adc_seq_pkg`:
  - state encoding constants (`S_IDLE`, `S_SETTLE`, `S_CONV`, `S_RELEASE`);
  - default `SIZE`/`NCH`/`CHW`.
- Sub-module `adc_res_fifo`:
  - parameterised width `SIZE+CHW` and depth `FDEPTH`;
  - `full`/`empty` flags;
  - simultaneous push/pop when full permitted.
- Next-channel logic: a combinational "next set bit above `ch_sel`" function, plus a "scan last" flag.

## Test plan
- Single scan:
  - Stimulus: `ch_mask = 4'b1010`, `settle_cyc = 3`, `trig` pulse; Ain of 0.24 V on ch1 and 1.20 V on ch3 (1.8 V full scale).
  - Response: FIFO holds {ch1, 34} then {ch3, 170}; `busy` drops; no second `sar_start`.
  - Check: `sar_start` rises exactly 4 cycles after SETTLE entry.
- Continuous scan:
  - Stimulus: `en = 1`, `ch_mask = 4'b1111`, `res_ready = 1`.
  - Response: results in channel order 0,1,2,3,0,1…
  - Stimulus: drop `en` during ch2.
  - Response: ch2 and ch3 still complete; then IDLE.
- Overrun:
  - Stimulus: `res_ready = 0`, `en = 1`, 4 channels.
  - Response: after 4 results, the 5th conversion sets `overrun`; FIFO contents remain the first 4.
  - Stimulus: `clr_ovr` pulse.
  - Response: `overrun` clears.
- Full FIFO with simultaneous pop:
  - Stimulus: a pop in the same cycle as a capture into a full FIFO.
  - Response: no overrun; entry order preserved.
- Empty mask and ignored trigger:
  - Stimulus: `ch_mask = 0` with `trig`.
  - Response: `busy` stays 0; no `sar_start`.
  - Stimulus: `trig` mid-scan.
  - Response: no extra scan.
- Reset mid-CONV:
  - Stimulus: `rstn` low for 1 cycle while `sar_start = 1`.
  - Response: next cycle `sar_start = 0`, `busy = 0`, `res_valid = 0`, `ch_sel = 0`.
